// File: rtl/soc_onchip_memory_dp.sv
// True-dual-port on-chip SRAM with two Avalon-MM slave ports (A: HPS bridge, B: GPU).
// Optional collision accounting when SOC_ONCHIP_MEM_COLLISION_CNT_EN is defined.
module soc_onchip_memory_dp #(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned ADDR_WIDTH   = 13,
  parameter int unsigned READ_LATENCY = 1,
  parameter string       INIT_FILE    = "soc_onchip_memory_dp.hex"
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    reset_req,
`ifdef SOC_ONCHIP_MEM_COLLISION_CNT_EN
  output logic [15:0]             collision_count,
  output logic                    collision_pulse,
`endif
  input  logic                    a_clken,
  input  logic                    a_chipselect,
  input  logic                    a_write,
  input  logic [ADDR_WIDTH-1:0]   a_address,
  input  logic [DATA_WIDTH/8-1:0] a_byteenable,
  input  logic [DATA_WIDTH-1:0]   a_writedata,
  output logic [DATA_WIDTH-1:0]   a_readdata,
  output logic                    a_readdatavalid,
  input  logic                    b_clken,
  input  logic                    b_chipselect,
  input  logic                    b_write,
  input  logic [ADDR_WIDTH-1:0]   b_address,
  input  logic [DATA_WIDTH/8-1:0] b_byteenable,
  input  logic [DATA_WIDTH-1:0]   b_writedata,
  output logic [DATA_WIDTH-1:0]   b_readdata,
  output logic                    b_readdatavalid
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned DEPTH    = 1 << ADDR_WIDTH;

  // INIT_FILE names the preload image consumed by the memory macro flow.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [1:0]            en;
  logic [1:0]            rd_acc;
  logic [1:0]            wr_acc;
  logic [ADDR_WIDTH-1:0] addr  [2];
  logic [BE_WIDTH-1:0]   be    [2];
  logic [DATA_WIDTH-1:0] wdata [2];
  logic                  collision;

  assign en[0]    = a_clken & ~reset_req;
  assign en[1]    = b_clken & ~reset_req;
  assign addr[0]  = a_address;
  assign addr[1]  = b_address;
  assign be[0]    = a_byteenable;
  assign be[1]    = b_byteenable;
  assign wdata[0] = a_writedata;
  assign wdata[1] = b_writedata;

  assign rd_acc[0] = en[0] & a_chipselect & ~a_write;
  assign rd_acc[1] = en[1] & b_chipselect & ~b_write;
  assign wr_acc[0] = reset_n & en[0] & a_chipselect & a_write;
  assign wr_acc[1] = reset_n & en[1] & b_chipselect & b_write;
  assign collision = wr_acc[0] & wr_acc[1] & (a_address == b_address);

  // Byte-lane writes; on a same-address collision port B is dropped entirely.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_WIDTH; i++) begin
      if (wr_acc[0] && be[0][i])
        mem[addr[0]][i*8 +: 8] <= wdata[0][i*8 +: 8];
      if (wr_acc[1] && !collision && be[1][i])
        mem[addr[1]][i*8 +: 8] <= wdata[1][i*8 +: 8];
    end
  end

  // Per-port read pipeline: frozen while the port is disabled.
  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [DATA_WIDTH-1:0]   dpipe [READ_LATENCY];
    logic [READ_LATENCY-1:0] vpipe;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    rvalid;

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        vpipe  <= '0;
        rvalid <= 1'b0;
        rdata  <= '0;
      end else if (en[p]) begin
        vpipe[0] <= rd_acc[p];
        if (rd_acc[p])
          dpipe[0] <= mem[addr[p]];
        for (int i = 1; i < READ_LATENCY; i++) begin
          vpipe[i] <= vpipe[i-1];
          dpipe[i] <= dpipe[i-1];
        end
        rvalid <= vpipe[READ_LATENCY-1];
        if (vpipe[READ_LATENCY-1])
          rdata <= dpipe[READ_LATENCY-1];
      end
    end
  end

  assign a_readdata      = g_port[0].rdata;
  assign a_readdatavalid = g_port[0].rvalid;
  assign b_readdata      = g_port[1].rdata;
  assign b_readdatavalid = g_port[1].rvalid;

`ifdef SOC_ONCHIP_MEM_COLLISION_CNT_EN
  // Saturating collision counter and one-cycle pulse, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      collision_count <= 16'd0;
      collision_pulse <= 1'b0;
    end else begin
      collision_pulse <= collision;
      if (collision && collision_count != 16'hFFFF)
        collision_count <= collision_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_soc_onchip_memory_dp.sv
// Directed bench for soc_onchip_memory_dp: one instance at READ_LATENCY 1, one at 2,
// driven with shared stimulus.
module tb_soc_onchip_memory_dp;

  logic        clk = 1'b0;
  logic        reset_n, reset_req;
  logic        a_clken, a_chipselect, a_write;
  logic [12:0] a_address;
  logic [7:0]  a_byteenable;
  logic [63:0] a_writedata;
  logic        b_clken, b_chipselect, b_write;
  logic [12:0] b_address;
  logic [7:0]  b_byteenable;
  logic [63:0] b_writedata;
  logic [63:0] a_rd1, b_rd1, a_rd2, b_rd2;
  logic        a_rv1, b_rv1, a_rv2, b_rv2;
`ifdef SOC_ONCHIP_MEM_COLLISION_CNT_EN
  logic [15:0] cc1, cc2;
  logic        cp1, cp2;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  soc_onchip_memory_dp u_lat1 (
    .clk(clk), .reset_n(reset_n), .reset_req(reset_req),
`ifdef SOC_ONCHIP_MEM_COLLISION_CNT_EN
    .collision_count(cc1), .collision_pulse(cp1),
`endif
    .a_clken(a_clken), .a_chipselect(a_chipselect), .a_write(a_write),
    .a_address(a_address), .a_byteenable(a_byteenable), .a_writedata(a_writedata),
    .a_readdata(a_rd1), .a_readdatavalid(a_rv1),
    .b_clken(b_clken), .b_chipselect(b_chipselect), .b_write(b_write),
    .b_address(b_address), .b_byteenable(b_byteenable), .b_writedata(b_writedata),
    .b_readdata(b_rd1), .b_readdatavalid(b_rv1)
  );

  soc_onchip_memory_dp #(.READ_LATENCY(2)) u_lat2 (
    .clk(clk), .reset_n(reset_n), .reset_req(reset_req),
`ifdef SOC_ONCHIP_MEM_COLLISION_CNT_EN
    .collision_count(cc2), .collision_pulse(cp2),
`endif
    .a_clken(a_clken), .a_chipselect(a_chipselect), .a_write(a_write),
    .a_address(a_address), .a_byteenable(a_byteenable), .a_writedata(a_writedata),
    .a_readdata(a_rd2), .a_readdatavalid(a_rv2),
    .b_clken(b_clken), .b_chipselect(b_chipselect), .b_write(b_write),
    .b_address(b_address), .b_byteenable(b_byteenable), .b_writedata(b_writedata),
    .b_readdata(b_rd2), .b_readdatavalid(b_rv2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset_req    = 1'b0;
    a_clken      = 1'b1;
    b_clken      = 1'b1;
    a_chipselect = 1'b0;
    a_write      = 1'b0;
    b_chipselect = 1'b0;
    b_write      = 1'b0;
  endtask

  task automatic drive_a(input bit wr, input logic [12:0] ad, input logic [63:0] d,
                         input logic [7:0] be);
    a_chipselect = 1'b1;
    a_write      = wr;
    a_address    = ad;
    a_writedata  = d;
    a_byteenable = be;
  endtask

  task automatic drive_b(input bit wr, input logic [12:0] ad, input logic [63:0] d,
                         input logic [7:0] be);
    b_chipselect = 1'b1;
    b_write      = wr;
    b_address    = ad;
    b_writedata  = d;
    b_byteenable = be;
  endtask

  // Issue one read and collect the data returned by each instance at its own latency.
  task automatic read_back(input bit port_b, input logic [12:0] ad,
                           output logic [63:0] d1, output logic v1,
                           output logic [63:0] d2, output logic v2);
    if (port_b) drive_b(1'b0, ad, 64'd0, 8'h00);
    else        drive_a(1'b0, ad, 64'd0, 8'h00);
    tick();
    idle();
    tick();
    d1 = port_b ? b_rd1 : a_rd1;
    v1 = port_b ? b_rv1 : a_rv1;
    tick();
    d2 = port_b ? b_rd2 : a_rd2;
    v2 = port_b ? b_rv2 : a_rv2;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle();
    a_address = '0; a_byteenable = '0; a_writedata = '0;
    b_address = '0; b_byteenable = '0; b_writedata = '0;
    repeat (3) tick();
    n_checks++;
    if ({a_rv1, b_rv1, a_rv2, b_rv2} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_valid: got %b expected 0000", {a_rv1, b_rv1, a_rv2, b_rv2});
    end
    n_checks++;
    if ((a_rd1 | b_rd1 | a_rd2 | b_rd2) !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_data: got %h %h %h %h expected 0", a_rd1, b_rd1, a_rd2, b_rd2);
    end
`ifdef SOC_ONCHIP_MEM_COLLISION_CNT_EN
    n_checks++;
    if ({cc1, cp1, cc2, cp2} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_collision: got %h %b %h %b expected 0", cc1, cp1, cc2, cp2);
    end
`endif
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_latency();
    drive_a(1'b1, 13'h0010, 64'h1122334455667788, 8'hFF);
    tick();
    idle();
    drive_b(1'b0, 13'h0010, 64'd0, 8'h00);
    tick();                                   // edge N
    idle();
    n_checks++;
    if (b_rv1 !== 1'b0 || b_rv2 !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_edgeN: got %b%b expected 00", b_rv1, b_rv2);
    end
    tick();                                   // edge N+1
    n_checks++;
    if (b_rv1 !== 1'b1 || b_rd1 !== 64'h1122334455667788 || b_rv2 !== 1'b0) begin
      n_fail++;
      $display("FAIL lat1_data: got v1=%b d1=%h v2=%b expected 1 1122334455667788 0",
               b_rv1, b_rd1, b_rv2);
    end
    tick();                                   // edge N+2
    n_checks++;
    if (b_rv2 !== 1'b1 || b_rd2 !== 64'h1122334455667788 || b_rv1 !== 1'b0) begin
      n_fail++;
      $display("FAIL lat2_data: got v2=%b d2=%h v1=%b expected 1 1122334455667788 0",
               b_rv2, b_rd2, b_rv1);
    end
    tick();
    n_checks++;
    if ({a_rv1, b_rv1, a_rv2, b_rv2} !== 4'b0000) begin
      n_fail++;
      $display("FAIL lat_single_pulse: got %b expected 0000", {a_rv1, b_rv1, a_rv2, b_rv2});
    end
  endtask

  task automatic test_byte_lanes();
    logic [63:0] d1, d2;
    logic        v1, v2;
    drive_a(1'b1, 13'h1FFF, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
    tick();
    idle();
    drive_b(1'b1, 13'h1FFF, 64'h00000000000000AA, 8'h01);
    tick();
    idle();
    read_back(1'b0, 13'h1FFF, d1, v1, d2, v2);
    n_checks++;
    if (v1 !== 1'b1 || d1 !== 64'hFFFFFFFFFFFFFFAA || v2 !== 1'b1 || d2 !== 64'hFFFFFFFFFFFFFFAA) begin
      n_fail++;
      $display("FAIL byte_lanes: got %b %h %b %h expected FFFFFFFFFFFFFFAA", v1, d1, v2, d2);
    end
  endtask

  task automatic test_collision();
    logic [63:0] d1, d2;
    logic        v1, v2;
    drive_a(1'b1, 13'h0100, 64'h1, 8'hFF);
    drive_b(1'b1, 13'h0100, 64'h2, 8'hFF);
    tick();
    idle();
`ifdef SOC_ONCHIP_MEM_COLLISION_CNT_EN
    n_checks++;
    if (cp1 !== 1'b1 || cc1 !== 16'd1 || cp2 !== 1'b1 || cc2 !== 16'd1) begin
      n_fail++;
      $display("FAIL coll_pulse: got p=%b c=%h expected 1 0001", cp1, cc1);
    end
    tick();
    n_checks++;
    if (cp1 !== 1'b0 || cc1 !== 16'd1) begin
      n_fail++;
      $display("FAIL coll_pulse_end: got p=%b c=%h expected 0 0001", cp1, cc1);
    end
`endif
    read_back(1'b1, 13'h0100, d1, v1, d2, v2);
    n_checks++;
    if (v1 !== 1'b1 || d1 !== 64'h1 || v2 !== 1'b1 || d2 !== 64'h1) begin
      n_fail++;
      $display("FAIL coll_a_wins: got %b %h %b %h expected 1", v1, d1, v2, d2);
    end
    // Port B's non-overlapping lanes must be dropped too.
    drive_a(1'b1, 13'h0101, 64'h0, 8'hFF);
    tick();
    drive_a(1'b1, 13'h0101, 64'h0000000000000011, 8'h01);
    drive_b(1'b1, 13'h0101, 64'h2222222222222222, 8'hFF);
    tick();
    idle();
    read_back(1'b0, 13'h0101, d1, v1, d2, v2);
    n_checks++;
    if (d1 !== 64'h11 || d2 !== 64'h11) begin
      n_fail++;
      $display("FAIL coll_b_dropped: got %h %h expected 0000000000000011", d1, d2);
    end
`ifdef SOC_ONCHIP_MEM_COLLISION_CNT_EN
    n_checks++;
    if (cc1 !== 16'd2 || cc2 !== 16'd2) begin
      n_fail++;
      $display("FAIL coll_count2: got %h %h expected 0002", cc1, cc2);
    end
    drive_a(1'b1, 13'h0102, 64'h5, 8'hFF);
    drive_b(1'b1, 13'h0102, 64'h6, 8'hFF);
    for (int i = 0; i < 65540; i++) tick();
    idle();
    tick();
    n_checks++;
    if (cc1 !== 16'hFFFF || cc2 !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL coll_saturate: got %h %h expected FFFF", cc1, cc2);
    end
`endif
  endtask

  task automatic test_mixed();
    logic [63:0] d1, d2;
    logic        v1, v2;
    drive_a(1'b1, 13'h0005, 64'hBEEF, 8'hFF);
    tick();
    idle();
    drive_a(1'b1, 13'h0005, 64'hDEAD, 8'hFF);
    drive_b(1'b0, 13'h0005, 64'd0, 8'h00);
    tick();
    idle();
`ifdef SOC_ONCHIP_MEM_COLLISION_CNT_EN
    n_checks++;
    if (cp1 !== 1'b0) begin
      n_fail++;
      $display("FAIL mixed_no_collision: got %b expected 0", cp1);
    end
`endif
    tick();
    n_checks++;
    if (b_rv1 !== 1'b1 || b_rd1 !== 64'hBEEF) begin
      n_fail++;
      $display("FAIL mixed_old1: got %b %h expected 1 BEEF", b_rv1, b_rd1);
    end
    tick();
    n_checks++;
    if (b_rv2 !== 1'b1 || b_rd2 !== 64'hBEEF) begin
      n_fail++;
      $display("FAIL mixed_old2: got %b %h expected 1 BEEF", b_rv2, b_rd2);
    end
    read_back(1'b1, 13'h0005, d1, v1, d2, v2);
    n_checks++;
    if (d1 !== 64'hDEAD || d2 !== 64'hDEAD || v1 !== 1'b1 || v2 !== 1'b1) begin
      n_fail++;
      $display("FAIL mixed_new: got %b %h %b %h expected DEAD", v1, d1, v2, d2);
    end
  endtask

  // use_req=0 stalls port A via a_clken; use_req=1 stalls port B via reset_req.
  task automatic test_stall(input bit use_req);
    logic [63:0] d1, d2;
    logic        v1, v2;
    drive_a(1'b1, 13'h0020, 64'hCAFE, 8'hFF);
    drive_b(1'b1, 13'h0021, 64'hF00D, 8'hFF);
    tick();
    idle();
    if (use_req) drive_b(1'b0, 13'h0020, 64'd0, 8'h00);
    else         drive_a(1'b0, 13'h0020, 64'd0, 8'h00);
    tick();                                   // edge N
    idle();
    tick();                                   // edge N+1
    v1 = use_req ? b_rv1 : a_rv1;
    d1 = use_req ? b_rd1 : a_rd1;
    n_checks++;
    if (v1 !== 1'b1 || d1 !== 64'hCAFE) begin
      n_fail++;
      $display("FAIL stall_pre(%0d): got %b %h expected 1 CAFE", use_req, v1, d1);
    end
    if (use_req) reset_req = 1'b1;
    else         a_clken   = 1'b0;
    // A request presented during the stall must not be taken.
    if (use_req) drive_b(1'b0, 13'h0021, 64'd0, 8'h00);
    else         drive_a(1'b0, 13'h0021, 64'd0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      v1 = use_req ? b_rv1 : a_rv1;
      d1 = use_req ? b_rd1 : a_rd1;
      v2 = use_req ? b_rv2 : a_rv2;
      n_checks++;
      if (v1 !== 1'b1 || d1 !== 64'hCAFE || v2 !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold(%0d,%0d): got v1=%b d1=%h v2=%b expected 1 CAFE 0",
                 use_req, i, v1, d1, v2);
      end
    end
    idle();
    tick();                                   // resume edge
    v1 = use_req ? b_rv1 : a_rv1;
    v2 = use_req ? b_rv2 : a_rv2;
    d2 = use_req ? b_rd2 : a_rd2;
    n_checks++;
    if (v1 !== 1'b0 || v2 !== 1'b1 || d2 !== 64'hCAFE) begin
      n_fail++;
      $display("FAIL stall_resume(%0d): got v1=%b v2=%b d2=%h expected 0 1 CAFE",
               use_req, v1, v2, d2);
    end
    tick();
    tick();
    n_checks++;
    if ({a_rv1, b_rv1, a_rv2, b_rv2} !== 4'b0000) begin
      n_fail++;
      $display("FAIL stall_no_accept(%0d): got %b expected 0000",
               use_req, {a_rv1, b_rv1, a_rv2, b_rv2});
    end
  endtask

  task automatic test_reset_midflight();
    logic [63:0] d1, d2;
    logic        v1, v2;
    drive_a(1'b1, 13'h0030, 64'h5A5A, 8'hFF);
    tick();
    idle();
    drive_a(1'b0, 13'h0030, 64'd0, 8'h00);
    tick();                                   // read accepted
    reset_n = 1'b0;
    drive_a(1'b1, 13'h0030, 64'hFFFF, 8'hFF); // ignored while in reset
    drive_b(1'b0, 13'h0030, 64'd0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({a_rv1, b_rv1, a_rv2, b_rv2} !== 4'b0000 || (a_rd1 | a_rd2 | b_rd1 | b_rd2) !== 64'd0) begin
        n_fail++;
        $display("FAIL rst_flight(%0d): got v=%b a2=%h expected 0", i,
                 {a_rv1, b_rv1, a_rv2, b_rv2}, a_rd2);
      end
    end
    idle();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({a_rv1, b_rv1, a_rv2, b_rv2} !== 4'b0000) begin
        n_fail++;
        $display("FAIL rst_no_return(%0d): got %b expected 0000", i,
                 {a_rv1, b_rv1, a_rv2, b_rv2});
      end
    end
    read_back(1'b1, 13'h0030, d1, v1, d2, v2);
    n_checks++;
    if (v1 !== 1'b1 || d1 !== 64'h5A5A || v2 !== 1'b1 || d2 !== 64'h5A5A) begin
      n_fail++;
      $display("FAIL rst_preserved: got %b %h %b %h expected 5A5A", v1, d1, v2, d2);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_byte_lanes();
    test_collision();
    test_mixed();
    test_stall(1'b0);
    test_stall(1'b1);
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
